// File: rtl/brush_stamper_if.sv
// rtl/brush_stamper_if.sv - point-in / plot-out signal bundle for brush_stamper
interface brush_stamper_if;
  logic [8:0] iX;
  logic [7:0] iY;
  logic       in_valid;
  logic [1:0] stencil_sel;
  logic [8:0] oX;
  logic [7:0] oY;
  logic       plot;
  logic       busy;
  logic       fifo_empty;
  logic [7:0] drop_count;

  modport master (
    output iX, iY, in_valid, stencil_sel,
    input  oX, oY, plot, busy, fifo_empty, drop_count
  );

  modport slave (
    input  iX, iY, in_valid, stencil_sel,
    output oX, oY, plot, busy, fifo_empty, drop_count
  );
endinterface

// File: rtl/brush_stamper.sv
// rtl/brush_stamper.sv - buffers detected points and expands each into a clipped brush stamp
module brush_stamper #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240
) (
  input  logic            clock50,
  input  logic            resetn,
  brush_stamper_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, STAMP} state_t;

  localparam logic [ADDR_W:0]        FULL_CNT = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic signed [10:0]     W_S      = 11'(SCREEN_W);
  localparam logic signed [10:0]     H_S      = 11'(SCREEN_H);

  logic [16:0]       mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [7:0]        drop_cnt;

  state_t            state;
  logic [8:0]        cx;
  logic [7:0]        cy;
  logic [1:0]        shape;
  logic signed [2:0] rad, dx, dy;
  logic [8:0]        ox_r;
  logic [7:0]        oy_r;
  logic              plot_r;

  logic              in_frame, full, push, drop, pop;
  logic [16:0]       head;
  logic signed [10:0] px, py;
  logic              px_ok, py_ok, mask;

  assign in_frame = (32'(bus.iX) < SCREEN_W) && (32'(bus.iY) < SCREEN_H);
  // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot for this push.
  assign full     = (count == FULL_CNT);
  assign push     = bus.in_valid && in_frame && !full;
  assign drop     = bus.in_valid && in_frame && full;
  assign pop      = (state == IDLE) && (count != '0);
  assign head     = mem[rd_ptr];

  assign px    = $signed({2'b00, cx}) + 11'(dx);
  assign py    = $signed({3'b000, cy}) + 11'(dy);
  assign px_ok = (px >= 0) && (px < W_S);
  assign py_ok = (py >= 0) && (py < H_S);
  assign mask  = (shape == 2'd3) ? ((dx == 3'sd0) || (dy == 3'sd0)) : 1'b1;

  always_ff @(posedge clock50) begin
    if (push) begin
      mem[wr_ptr] <= {bus.iX, bus.iY};
    end
  end

  always_ff @(posedge clock50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock50 or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cx     <= '0;
      cy     <= '0;
      shape  <= '0;
      rad    <= '0;
      dx     <= '0;
      dy     <= '0;
      ox_r   <= '0;
      oy_r   <= '0;
      plot_r <= 1'b0;
    end else begin
      plot_r <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cx    <= head[16:8];
            cy    <= head[7:0];
            shape <= bus.stencil_sel;
            rad   <= (bus.stencil_sel == 2'd0) ? 3'sd0 :
                     (bus.stencil_sel == 2'd1) ? 3'sd1 : 3'sd2;
            state <= LOAD;
          end
        end
        LOAD: begin
          dx    <= -rad;
          dy    <= -rad;
          state <= STAMP;
        end
        STAMP: begin
          // Clipped/masked offsets still take a cycle so stamp length is shape-fixed.
          ox_r   <= px[8:0];
          oy_r   <= py[7:0];
          plot_r <= px_ok && py_ok && mask;
          if (dx == rad) begin
            dx <= -rad;
            dy <= dy + 3'sd1;
            if (dy == rad) state <= IDLE;
          end else begin
            dx <= dx + 3'sd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oX         = ox_r;
  assign bus.oY         = oy_r;
  assign bus.plot       = plot_r;
  assign bus.busy       = (state != IDLE);
  assign bus.fifo_empty = (count == '0);
  assign bus.drop_count = drop_cnt;

endmodule

// File: tb/tb_brush_stamper.sv
// tb/tb_brush_stamper.sv - directed self-checking bench for brush_stamper
module tb_brush_stamper;

  typedef int arr9_t[9];

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   bcyc;
  int   w;

  logic [8:0] qx[$];
  logic [7:0] qy[$];

  always #10 clk = ~clk;

  brush_stamper_if bif();

  brush_stamper dut (
    .clock50 (clk),
    .resetn  (rst_n),
    .bus     (bif)
  );

  always @(negedge clk) begin
    if (bif.plot === 1'b1) begin
      qx.push_back(bif.oX);
      qy.push_back(bif.oY);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stamp_one(input logic [8:0] x, input logic [7:0] y, input logic [1:0] sel,
                           output int busy_cyc);
    qx.delete();
    qy.delete();
    bif.iX = x;
    bif.iY = y;
    bif.stencil_sel = sel;
    bif.in_valid = 1'b1;
    step();
    bif.in_valid = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bif.busy === 1'b1) busy_cyc++;
    end
  endtask

  task automatic cmp_plots(input string tag, input arr9_t ex, input arr9_t ey);
    int n;
    chk({tag, "_count"}, qx.size(), 9);
    n = (qx.size() < 9) ? qx.size() : 9;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_x%0d", tag, i), qx[i], ex[i]);
      chk($sformatf("%s_y%0d", tag, i), qy[i], ey[i]);
    end
  endtask

  arr9_t e2x = '{9, 10, 11, 9, 10, 11, 9, 10, 11};
  arr9_t e2y = '{9, 9, 9, 10, 10, 10, 11, 11, 11};
  arr9_t e3x = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  arr9_t e3y = '{237, 237, 237, 238, 238, 238, 239, 239, 239};
  arr9_t e4x = '{50, 50, 48, 49, 50, 51, 52, 50, 50};
  arr9_t e4y = '{48, 49, 50, 50, 50, 50, 50, 51, 52};

  initial begin
    rst_n = 1'b0;
    bif.iX = '0;
    bif.iY = '0;
    bif.in_valid = 1'b0;
    bif.stencil_sel = '0;
    step(2);
    chk("rst_oX", bif.oX, 0);
    chk("rst_oY", bif.oY, 0);
    chk("rst_plot", bif.plot, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_empty", bif.fifo_empty, 1);
    chk("rst_drop", bif.drop_count, 0);
    rst_n = 1'b1;
    step();

    // dot at (100,50): first plot three edges after capture
    bif.iX = 9'd100;
    bif.iY = 8'd50;
    bif.stencil_sel = 2'd0;
    bif.in_valid = 1'b1;
    step();
    bif.in_valid = 1'b0;
    chk("dot_e0_empty", bif.fifo_empty, 0);
    chk("dot_e0_busy", bif.busy, 0);
    step();
    chk("dot_e1_busy", bif.busy, 1);
    chk("dot_e1_plot", bif.plot, 0);
    step();
    chk("dot_e2_busy", bif.busy, 1);
    chk("dot_e2_plot", bif.plot, 0);
    step();
    chk("dot_e3_plot", bif.plot, 1);
    chk("dot_e3_x", bif.oX, 100);
    chk("dot_e3_y", bif.oY, 50);
    step();
    chk("dot_e4_plot", bif.plot, 0);
    chk("dot_e4_busy", bif.busy, 0);
    chk("dot_e4_empty", bif.fifo_empty, 1);
    chk("dot_drop", bif.drop_count, 0);

    stamp_one(9'd10, 8'd10, 2'd1, bcyc);
    chk("sq3_busy", bcyc, 10);
    cmp_plots("sq3", e2x, e2y);

    stamp_one(9'd0, 8'd239, 2'd2, bcyc);
    chk("sq5clip_busy", bcyc, 26);
    cmp_plots("sq5clip", e3x, e3y);

    stamp_one(9'd50, 8'd50, 2'd3, bcyc);
    chk("plus_busy", bcyc, 26);
    cmp_plots("plus", e4x, e4y);

    // overflow: 40 back-to-back points, 18 survive, 22 dropped
    qx.delete();
    qy.delete();
    bif.stencil_sel = 2'd2;
    for (int i = 0; i < 40; i++) begin
      bif.iX = 9'(20 + i);
      bif.iY = 8'd100;
      bif.in_valid = 1'b1;
      step();
    end
    bif.in_valid = 1'b0;
    chk("ovf_drop", bif.drop_count, 22);
    chk("ovf_empty", bif.fifo_empty, 0);
    w = 0;
    while ((bif.busy !== 1'b0 || bif.fifo_empty !== 1'b1) && w < 1200) begin
      step();
      w++;
    end
    chk("ovf_drain_timeout", (w < 1200), 1);
    step(3);
    chk("ovf_plots", qx.size(), 450);
    if (qx.size() >= 450) begin
      for (int g = 0; g < 18; g++) begin
        chk($sformatf("ovf_cx%0d", g), qx[g*25+12], (g < 17) ? 20 + g : 49);
        chk($sformatf("ovf_cy%0d", g), qy[g*25+12], 100);
      end
    end
    chk("ovf_drop_hold", bif.drop_count, 22);

    // async reset mid-stamp with 5 entries still queued
    for (int i = 0; i < 6; i++) begin
      bif.iX = 9'(200 + i);
      bif.iY = 8'd120;
      bif.in_valid = 1'b1;
      step();
    end
    bif.in_valid = 1'b0;
    step(8);
    chk("pre_rst_plot", bif.plot, 1);
    chk("pre_rst_busy", bif.busy, 1);
    chk("pre_rst_empty", bif.fifo_empty, 0);
    #5;
    rst_n = 1'b0;
    #1;
    chk("arst_plot", bif.plot, 0);
    chk("arst_busy", bif.busy, 0);
    chk("arst_drop", bif.drop_count, 0);
    chk("arst_empty", bif.fifo_empty, 1);
    chk("arst_oX", bif.oX, 0);
    step();
    rst_n = 1'b1;
    qx.delete();
    qy.delete();
    step(40);
    chk("post_rst_plots", qx.size(), 0);
    chk("post_rst_busy", bif.busy, 0);
    chk("post_rst_empty", bif.fifo_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
